// File: rtl/nba_lockstep_monitor.sv
// nba_lockstep_monitor
// Passive reader-side monitor for two nominally identical signals. It flags any
// cycle where they differ, timestamps the first difference, and measures the
// widths of high pulses on A. Inputs are used directly at the clock edge and
// every output is registered, so results appear one cycle after the sample.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | A low, no pulse in progress
// ST_HIGH   | A high, len counts the cycles of the current pulse
// ST_DONE   | A pulse just ended; pulse_len_o/pulse_vld_o show it this cycle
module nba_lockstep_monitor #(
  parameter int CNT_W = 8,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             clear_i,
  output logic [CYC_W-1:0] cycle_o,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic [CYC_W-1:0] first_err_o,
  output logic [CNT_W-1:0] pulse_len_o,
  output logic             pulse_vld_o,
  output logic [CNT_W-1:0] pulse_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CYC_W-1:0] CYC_MAX = '1;
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] len;
  logic             a_hi;
  logic             diff;

  // An unknown on either side must count as a difference, and only a clean 1
  // on A may start or extend a pulse.
  assign diff = (a_i !== b_i);
  assign a_hi = (a_i === 1'b1);

  // Free-running saturating cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_o <= '0;
    end else if (cycle_o != CYC_MAX) begin
      cycle_o <= cycle_o + CYC_ONE;
    end
  end

  // Mismatch tracking; a clear discards any difference sampled in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      mismatch_o     <= 1'b0;
      mismatch_cnt_o <= '0;
      first_err_o    <= '0;
    end else if (diff) begin
      if (mismatch_cnt_o != CNT_MAX) begin
        mismatch_cnt_o <= mismatch_cnt_o + CNT_ONE;
      end
      if (!mismatch_o) begin
        mismatch_o  <= 1'b1;
        first_err_o <= cycle_o;
      end
    end
  end

  // Pulse-width FSM on A. Results are registered on the edge that leaves
  // ST_HIGH, so pulse_vld_o is high exactly while the FSM sits in ST_DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      len         <= '0;
      pulse_len_o <= '0;
      pulse_vld_o <= 1'b0;
      pulse_cnt_o <= '0;
    end else begin
      pulse_vld_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (a_hi) begin
            state <= ST_HIGH;
            len   <= CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (a_hi) begin
            if (len != CNT_MAX) begin
              len <= len + CNT_ONE;
            end
          end else begin
            state       <= ST_DONE;
            pulse_len_o <= len;
            pulse_vld_o <= 1'b1;
            if (pulse_cnt_o != CNT_MAX) begin
              pulse_cnt_o <= pulse_cnt_o + CNT_ONE;
            end
          end
        end
        ST_DONE: begin
          // A single low cycle between pulses is legal; restart immediately.
          if (a_hi) begin
            state <= ST_HIGH;
            len   <= CNT_ONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nba_lockstep_monitor.sv
// Bench for nba_lockstep_monitor: a default-width instance plus a CNT_W=2
// instance sharing the same stimulus (for saturation). Vectors with expected
// values (-1 = don't care) are listed up front, pushed to a scoreboard queue as
// they are driven, and popped/compared one cycle later.
module tb_nba_lockstep_monitor;

  localparam int D = -1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_i = 1'b0;
  logic        b_i = 1'b0;
  logic        clear_i = 1'b0;

  logic [15:0] cycle_o, first_err_o;
  logic        mismatch_o, pulse_vld_o;
  logic [7:0]  mismatch_cnt_o, pulse_len_o, pulse_cnt_o;

  logic [15:0] cycle2, first_err2;
  logic        mismatch2, pulse_vld2;
  logic [1:0]  mismatch_cnt2, pulse_len2, pulse_cnt2;

  nba_lockstep_monitor #(.CNT_W(8), .CYC_W(16)) dut (
    .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .clear_i(clear_i),
    .cycle_o(cycle_o), .mismatch_o(mismatch_o), .mismatch_cnt_o(mismatch_cnt_o),
    .first_err_o(first_err_o), .pulse_len_o(pulse_len_o),
    .pulse_vld_o(pulse_vld_o), .pulse_cnt_o(pulse_cnt_o)
  );

  nba_lockstep_monitor #(.CNT_W(2), .CYC_W(16)) dut2 (
    .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .clear_i(clear_i),
    .cycle_o(cycle2), .mismatch_o(mismatch2), .mismatch_cnt_o(mismatch_cnt2),
    .first_err_o(first_err2), .pulse_len_o(pulse_len2),
    .pulse_vld_o(pulse_vld2), .pulse_cnt_o(pulse_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r, a, b, c;
    int cyc, mm, mcnt, ferr, plen, pvld, pcnt, plen2, mcnt2;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input bit r, input bit a, input bit b, input bit c,
                     input int cyc, input int mm, input int mcnt, input int ferr,
                     input int plen, input int pvld, input int pcnt,
                     input int plen2, input int mcnt2);
    vec_t v;
    v.r = r; v.a = a; v.b = b; v.c = c;
    v.cyc = cyc; v.mm = mm; v.mcnt = mcnt; v.ferr = ferr;
    v.plen = plen; v.pvld = pvld; v.pcnt = pcnt; v.plen2 = plen2; v.mcnt2 = mcnt2;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        failures++;
        $display("FAIL %s vec=%0d actual=%0d required=%0d", nm, idx, act, exp);
      end
    end
  endtask

  task automatic reset_vec(input bit a, input bit b);
    add(1, a, b, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vec_t e;

    // 1: reset then ten quiet cycles
    reset_vec(0, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 0, k, 0, D, D, D, D, D, D, D);
    add(0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0);

    // 2: 3-cycle pulse starting at cycle 5, B identical
    reset_vec(0, 0);
    for (int k = 0; k <= 4; k++) add(0, 0, 0, 0, k + 1, D, D, D, D, D, D, D, D);
    add(0, 1, 1, 0, 6, D, D, D, D, 0, 0, D, D);
    add(0, 1, 1, 0, 7, D, D, D, D, 0, 0, D, D);
    add(0, 1, 1, 0, 8, D, D, D, D, 0, 0, D, D);
    add(0, 0, 0, 0, 9, 0, 0, 0, 3, 1, 1, 3, 0);
    add(0, 0, 0, 0, 10, D, D, D, 3, 0, 1, D, D);

    // 3: mismatches at 7 and 12 inside a long pulse, clear at 15, mismatch at 18
    reset_vec(0, 0);
    for (int k = 0; k <= 4; k++) add(0, 0, 0, 0, k + 1, D, D, D, D, D, D, D, D);
    add(0, 1, 1, 0, 6, 0, 0, D, D, D, D, D, D);
    add(0, 1, 1, 0, 7, 0, 0, D, D, D, D, D, D);
    add(0, 1, 0, 0, 8, 1, 1, 7, D, 0, 0, D, 1);
    for (int k = 8; k <= 10; k++) add(0, 1, 1, 0, k + 1, D, D, D, D, D, D, D, D);
    add(0, 1, 1, 0, 12, 1, 1, 7, D, D, D, D, D);
    add(0, 1, 0, 0, 13, 1, 2, 7, D, 0, 0, D, 2);
    add(0, 1, 1, 0, 14, D, D, D, D, D, D, D, D);
    add(0, 0, 0, 0, 15, 1, 2, 7, 9, 1, 1, 3, 2);
    add(0, 0, 1, 1, 16, 0, 0, 0, 9, 0, 1, 3, 0);
    add(0, 0, 0, 0, 17, 0, 0, 0, D, D, D, D, D);
    add(0, 0, 0, 0, 18, 0, 0, 0, D, D, D, D, D);
    add(0, 0, 1, 0, 19, 1, 1, 18, 9, 0, 1, D, 1);
    add(0, 0, 0, 0, 20, 1, 1, 18, D, D, D, D, D);

    // 4: pulse on first post-reset edge, back-to-back 1,1,0,1,0, then a 6-cycle pulse
    reset_vec(0, 0);
    add(0, 1, 1, 0, 1, D, D, D, D, 0, 0, D, D);
    add(0, 1, 1, 0, 2, D, D, D, D, 0, 0, D, D);
    add(0, 0, 0, 0, 3, 0, 0, 0, 2, 1, 1, 2, 0);
    add(0, 1, 1, 0, 4, D, D, D, 2, 0, 1, D, D);
    add(0, 0, 0, 0, 5, D, D, D, 1, 1, 2, 1, D);
    add(0, 0, 0, 0, 6, D, D, D, 1, 0, 2, D, D);
    for (int k = 6; k <= 11; k++) add(0, 1, 1, 0, k + 1, D, D, D, D, 0, D, D, D);
    add(0, 0, 0, 0, 13, 0, 0, 0, 6, 1, 3, 3, 0);
    add(0, 1, 0, 0, 14, 1, 1, 13, 6, 0, 3, D, 1);
    add(0, 1, 1, 0, 15, D, D, D, D, D, D, D, D);

    // 5: reset mid-pulse (A still high, B differing), then a 4-cycle pulse
    reset_vec(1, 0);
    for (int k = 0; k <= 3; k++) add(0, 1, 1, 0, k + 1, D, D, D, D, 0, 0, D, D);
    add(0, 0, 0, 0, 5, 0, 0, 0, 4, 1, 1, 3, 0);
    // run of mismatches to saturate the 2-bit mismatch counter
    add(0, 0, 1, 0, 6, 1, 1, 5, 4, 0, 1, D, 1);
    add(0, 0, 1, 0, 7, 1, 2, 5, D, D, D, D, 2);
    add(0, 0, 1, 0, 8, 1, 3, 5, D, D, D, D, 3);
    add(0, 0, 1, 0, 9, 1, 4, 5, D, D, D, D, 3);
    add(0, 0, 1, 0, 10, 1, 5, 5, D, D, D, D, 3);
    add(0, 0, 0, 0, 11, 1, 5, 5, 4, 0, 1, D, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r; a_i = tbl[i].a; b_i = tbl[i].b; clear_i = tbl[i].c;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", i);
      end else begin
        e = exp_q.pop_front();
        chk("cycle",      i, int'(cycle_o),        e.cyc);
        chk("mismatch",   i, int'(mismatch_o),     e.mm);
        chk("mm_cnt",     i, int'(mismatch_cnt_o), e.mcnt);
        chk("first_err",  i, int'(first_err_o),    e.ferr);
        chk("pulse_len",  i, int'(pulse_len_o),    e.plen);
        chk("pulse_vld",  i, int'(pulse_vld_o),    e.pvld);
        chk("pulse_cnt",  i, int'(pulse_cnt_o),    e.pcnt);
        chk("pulse_len2", i, int'(pulse_len2),     e.plen2);
        chk("mm_cnt2",    i, int'(mismatch_cnt2),  e.mcnt2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nba_lockstep_monitor.md
Name: nba_lockstep_monitor

Overview:
- Reader-side monitor for NBA/timing regression benches. A DUT process drives two nominally identical signals through nonblocking writes with variable delays; this block consumes them.
- Each clock it samples both signals and reports any lockstep mismatch, including the cycle of the first mismatch.
- Measures high-pulse widths on signal A so the bench can check delay-dependent pulse lengths.
- Pure observer: never drives the DUT.

Parameters:
- CNT_W, 8, width of pulse-length and mismatch counters (saturating).
- CYC_W, 16, width of free-running cycle counter and first-error timestamp (saturating).

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- a_i  input  1  observed signal A, reference copy.
- b_i  input  1  observed signal B, must equal A every sampled cycle.
- clear_i  input  1  synchronous clear of error state (sticky flag, mismatch count, first-error stamp); does not clear the cycle counter or pulse FSM.
- cycle_o  output  CYC_W  cycles since reset.
- mismatch_o  output  1  sticky: set once a_i != b_i has been sampled.
- mismatch_cnt_o  output  CNT_W  number of mismatching samples.
- first_err_o  output  CYC_W  cycle_o value at the first mismatch since reset/clear.
- pulse_len_o  output  CNT_W  width in cycles of the last completed A high pulse.
- pulse_vld_o  output  1  one-cycle strobe when pulse_len_o updates.
- pulse_cnt_o  output  CNT_W  number of completed A high pulses.

Behaviour:
- Reset (rst=1 at posedge): every output is 0 on the following cycle. FSM goes to IDLE. The internal length counter is 0. rst has priority over clear_i and all sampling.
- Sampling: a_i and b_i are used directly at posedge, with no input flop. All outputs are registered, so latency is 1 cycle from the sampled edge to the output change.
- Cycle counter: increments every non-reset cycle and saturates at all-ones.
- Mismatch path (a_i != b_i at posedge):
  - mismatch_cnt_o increments, saturating at 2^CNT_W-1.
  - If mismatch_o was 0: mismatch_o is set to 1 and first_err_o captures the current cycle_o (the pre-increment value).
  - Later mismatches leave first_err_o unchanged.
- clear_i=1:
  - mismatch_o, mismatch_cnt_o and first_err_o are all cleared to 0.
  - If a mismatch is sampled in the same cycle as clear_i, clear wins and that sample is discarded.
- Pulse FSM on a_i:
  - IDLE: a_i=1 -> HIGH with len=1. a_i=0 -> stay in IDLE.
  - HIGH: a_i=1 -> len increments, saturating at 2^CNT_W-1. a_i=0 -> DONE.
  - DONE (one cycle):
    - pulse_len_o <= len and pulse_vld_o=1; pulse_cnt_o increments, saturating.
    - If a_i=1 in this cycle, go to HIGH with len=1 (back-to-back pulses; the single low cycle is legal). Otherwise go to IDLE.
  - pulse_vld_o is 0 in every state other than DONE.
- A pulse still high at reset is discarded. A pulse still high at end of simulation is never reported.
- A high on a_i present on the very first post-reset edge counts as a pulse start.
- X/Z on inputs: comparison uses !==, so an X on one side counts as a mismatch. The FSM treats a non-1 value as 0.

Test Plan:
- Reset, then a_i=b_i=0 for 10 cycles -> all outputs 0 except cycle_o=10; mismatch_o stays 0.
- After reset, drive a_i high for 3 cycles starting at cycle 5, with b_i identical:
  - pulse_vld_o strobes once with pulse_len_o=3 and pulse_cnt_o=1.
  - mismatch_cnt_o=0.
- Force b_i=0 while a_i=1 at cycle 7 and again at cycle 12:
  - mismatch_o=1, first_err_o=7, mismatch_cnt_o=2.
  - Pulse on A still measured correctly.
- Assert clear_i at cycle 15 concurrent with a mismatch -> mismatch_o=0, mismatch_cnt_o=0, first_err_o=0. A mismatch at cycle 18 -> first_err_o=18.
- Back-to-back pulses on A, pattern 1,1,0,1,0 -> two strobes with lengths 2 then 1, pulse_cnt_o=2. With CNT_W=2, a 6-cycle pulse -> pulse_len_o=3 (saturated).
- Assert rst mid-pulse (A high for 2 cycles) -> all outputs 0 next cycle. Keep A high 4 more cycles after release, then drop -> pulse_len_o=4.
